// File: rtl/regfile8_pkg.sv
// Shared operand-path constants and helpers for the regfile / ALU / control stages.
package regfile8_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

  // True when a read/write of this address hits the hardwired-zero R0.
  function automatic logic zero_hit(input int unsigned addr, input bit zero_reg);
    return zero_reg && (addr == 0);
  endfunction

endpackage

// File: rtl/regfile8_if.sv
// Write port, read request and registered read response of the operand regfile.
interface regfile8_if
  import regfile8_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rd_valid;

  modport master (
    output we, waddr, wdata, rd_en, raddr_a, raddr_b,
    input  a, b, rd_valid
  );

  modport slave (
    input  we, waddr, wdata, rd_en, raddr_a, raddr_b,
    output a, b, rd_valid
  );
endinterface

// File: rtl/regfile8_reg8.sv
// Enabled DATA_W-wide register with synchronous clear; storage cell and output stage.
module reg8
  import regfile8_pkg::*;
#(
  parameter int W = RF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear dominates load.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile8.sv
// 8x8 operand register file: one write port, two registered read ports with
// write-first bypass and an optional hardwired-zero R0.
module regfile8
  import regfile8_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input logic       clk,
  input logic       rst,
  regfile8_if.slave bus
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             wr_en;
  logic [DATA_W-1:0]               rdata_a;
  logic [DATA_W-1:0]               rdata_b;
  logic                            vld_q;

  // Write-first read of one port: R0 zero wins, then the in-flight write, then storage.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0]                ra,
    input logic                             we,
    input logic [ADDR_W-1:0]                wa,
    input logic [DATA_W-1:0]                wd,
    input logic [NUM_REGS-1:0][DATA_W-1:0]  regs
  );
    if (zero_hit(int'(ra), ZERO_REG)) return '0;
    if (we && (wa == ra))             return wd;
    return regs[ra];
  endfunction

  // Storage array; writes to a hardwired-zero R0 are simply never enabled.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr_en[i] = bus.we && (bus.waddr == ADDR_W'(i)) && !zero_hit(i, ZERO_REG);

    reg8 #(.W(DATA_W)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wr_en[i]),
      .d   (bus.wdata),
      .q   (regs_q[i])
    );
  end

  // Read muxes with bypass compare for both ports.
  always_comb begin
    rdata_a = rd_sel(bus.raddr_a, bus.we, bus.waddr, bus.wdata, regs_q);
    rdata_b = rd_sel(bus.raddr_b, bus.we, bus.waddr, bus.wdata, regs_q);
  end

  // Output registers load only on a read strobe, so a/b hold between reads.
  reg8 #(.W(DATA_W)) u_out_a (
    .clk (clk),
    .rst (rst),
    .en  (bus.rd_en),
    .d   (rdata_a),
    .q   (bus.a)
  );

  reg8 #(.W(DATA_W)) u_out_b (
    .clk (clk),
    .rst (rst),
    .en  (bus.rd_en),
    .d   (rdata_b),
    .q   (bus.b)
  );

  // Valid follows the read strobe by one cycle.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= bus.rd_en;
  end

  assign bus.rd_valid = vld_q;

endmodule
